// File: rtl/toggle_event_gen.sv
// Toggle coverage monitor: reports the first (or every) rise/fall of each sig bit as a
// one-cycle valid pulse and tracks how many distinct rise/fall points have been seen.
module toggle_event_gen #(
    parameter int WIDTH         = 20,
    parameter int STICKY        = 1,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [WIDTH-1:0]                   sig,
    input  logic                               en,
    input  logic                               clear,
    output logic [2*WIDTH-1:0]                 valid,
    output logic [$clog2(2*WIDTH+1)-1:0]       covered_count,
    output logic                               all_covered
);
    localparam int NPTS = 2 * WIDTH;
    localparam int CW   = $clog2(NPTS + 1);
    localparam int SCW  = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

    typedef enum logic [1:0] {INIT, SETTLE, ARMED} state_t;

    state_t            state, state_nxt;
    logic [SCW-1:0]    settle_cnt, settle_nxt;
    logic [WIDTH-1:0]  prev;
    logic [NPTS-1:0]   hit, hit_nxt, ev, valid_nxt;
    logic [CW-1:0]     cnt_nxt;

    function automatic logic [CW-1:0] popcount(input logic [NPTS-1:0] v);
        popcount = '0;
        for (int i = 0; i < NPTS; i++)
            popcount = popcount + CW'(v[i]);
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= INIT;
            settle_cnt <= '0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_nxt;
        end
    end

    // Clear behaves like a fresh INIT: reload the settle window (or arm at once).
    always_comb begin
        state_nxt  = state;
        settle_nxt = settle_cnt;
        if (clear || state == INIT) begin
            if (SETTLE_CYCLES == 0) begin
                state_nxt = ARMED;
            end else begin
                state_nxt  = SETTLE;
                settle_nxt = SCW'(SETTLE_CYCLES);
            end
        end else if (state == SETTLE) begin
            settle_nxt = settle_cnt - SCW'(1);
            if (settle_cnt <= SCW'(1))
                state_nxt = ARMED;
        end
    end

    always_comb begin
        ev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ev[2*i]   = ~prev[i] &  sig[i];
            ev[2*i+1] =  prev[i] & ~sig[i];
        end
        // Events are only qualified when armed and enabled; clear drops them entirely.
        if (state != ARMED || !en || clear)
            ev = '0;
        hit_nxt   = clear ? '0 : (hit | ev);
        valid_nxt = (STICKY != 0) ? (ev & ~hit) : ev;
        cnt_nxt   = popcount(hit_nxt);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev          <= '0;
            hit           <= '0;
            valid         <= '0;
            covered_count <= '0;
            all_covered   <= 1'b0;
        end else begin
            prev          <= sig;
            hit           <= hit_nxt;
            valid         <= valid_nxt;
            covered_count <= cnt_nxt;
            all_covered   <= (cnt_nxt == CW'(NPTS));
        end
    end
endmodule
